// File: rtl/param_bank_arbiter.sv
// Arbitrates one single-port PID parameter RAM between a buffered UART write
// path and two round-robin read clients (PID core on port A, UART read-back on port B).
module param_bank_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              wr_pulse,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic              rd_ack_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic              rd_req_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              rd_ack_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              ovf_clr,
  output logic              wr_overflow,
  output logic              busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_RDATA = 3'd3,
    ST_ACK   = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic              gnt_b_r, gnt_b_s;   // port of the current/last read grant (1 = B)
  logic              wbuf_valid_r;
  logic [ADDR_W-1:0] wbuf_addr_r;
  logic [DATA_W-1:0] wbuf_data_r;
  logic              wr_accept_s, wr_drop_s;

  // State and grant registers
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      gnt_b_r <= 1'b1;
    end else begin
      state_r <= state_s;
      gnt_b_r <= gnt_b_s;
    end
  end

  // Next-state and round-robin grant decision
  always_comb begin
    state_s = state_r;
    gnt_b_s = gnt_b_r;
    case (state_r)
      ST_IDLE: begin
        if (wbuf_valid_r) begin
          state_s = ST_WRITE;
        end else if (rd_req_a && !rd_req_b) begin
          state_s = ST_READ;
          gnt_b_s = 1'b0;
        end else if (!rd_req_a && rd_req_b) begin
          state_s = ST_READ;
          gnt_b_s = 1'b1;
        end else if (rd_req_a && rd_req_b) begin
          state_s = ST_READ;
          gnt_b_s = !gnt_b_r;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE: state_s = ST_IDLE;
      ST_READ:  state_s = ST_RDATA;
      ST_RDATA: state_s = ST_ACK;
      ST_ACK:   state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // A write landing in the draining WRITE cycle refills the buffer instead of overflowing
  always_comb begin
    wr_accept_s = 1'b0;
    wr_drop_s   = 1'b0;
    if (wr_pulse) begin
      if (!wbuf_valid_r || (state_r == ST_WRITE)) begin
        wr_accept_s = 1'b1;
      end else begin
        wr_drop_s = 1'b1;
      end
    end else begin
      wr_accept_s = 1'b0;
    end
  end

  // One-deep write buffer and sticky overflow flag (set beats clear)
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      wbuf_valid_r <= 1'b0;
      wbuf_addr_r  <= {ADDR_W{1'b0}};
      wbuf_data_r  <= {DATA_W{1'b0}};
      wr_overflow  <= 1'b0;
    end else begin
      if (wr_accept_s) begin
        wbuf_valid_r <= 1'b1;
        wbuf_addr_r  <= wr_addr;
        wbuf_data_r  <= wr_data;
      end else if (state_r == ST_WRITE) begin
        wbuf_valid_r <= 1'b0;
      end
      if (wr_drop_s) begin
        wr_overflow <= 1'b1;
      end else if (ovf_clr) begin
        wr_overflow <= 1'b0;
      end
    end
  end

  // Registered RAM and client outputs, decoded from the state being entered
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
      rd_ack_a  <= 1'b0;
      rd_ack_b  <= 1'b0;
      rd_data_a <= {DATA_W{1'b0}};
      rd_data_b <= {DATA_W{1'b0}};
      busy      <= 1'b0;
    end else begin
      mem_en <= (state_s == ST_WRITE) || (state_s == ST_READ);
      mem_we <= (state_s == ST_WRITE);
      case (state_s)
        ST_WRITE: begin
          mem_addr  <= wbuf_addr_r;
          mem_wdata <= wbuf_data_r;
        end
        ST_READ: begin
          mem_addr  <= gnt_b_s ? rd_addr_b : rd_addr_a;
          mem_wdata <= {DATA_W{1'b0}};
        end
        default: begin
          mem_addr  <= {ADDR_W{1'b0}};
          mem_wdata <= {DATA_W{1'b0}};
        end
      endcase
      rd_ack_a <= (state_s == ST_ACK) && !gnt_b_s;
      rd_ack_b <= (state_s == ST_ACK) && gnt_b_s;
      if ((state_r == ST_RDATA) && !gnt_b_r) begin
        rd_data_a <= mem_rdata;
      end
      if ((state_r == ST_RDATA) && gnt_b_r) begin
        rd_data_b <= mem_rdata;
      end
      busy <= (state_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_param_bank_arbiter.sv
// Scoreboarded random + directed bench for param_bank_arbiter with a RAM model
// and a transaction-level reference memory / round-robin model.
module tb_param_bank_arbiter;
  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk_in = 1'b0;
  logic          reset;
  logic          wr_pulse;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_req_a, rd_req_b;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic          rd_ack_a, rd_ack_b;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          ovf_clr, wr_overflow, busy;

  always #5 clk_in = ~clk_in;

  param_bank_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_in(clk_in), .reset(reset),
    .wr_pulse(wr_pulse), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req_a(rd_req_a), .rd_addr_a(rd_addr_a), .rd_ack_a(rd_ack_a), .rd_data_a(rd_data_a),
    .rd_req_b(rd_req_b), .rd_addr_b(rd_addr_b), .rd_ack_b(rd_ack_b), .rd_data_b(rd_data_b),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .ovf_clr(ovf_clr), .wr_overflow(wr_overflow), .busy(busy)
  );

  // Parameter RAM: synchronous write, one-cycle registered read
  logic [DW-1:0] ram [0:15];
  always @(posedge clk_in) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Reference model and scoreboard queues
  logic [DW-1:0]    ref_mem [0:15];
  bit               last_b_m;
  logic [AW+DW-1:0] exp_wr_q [$];
  logic [DW-1:0]    exp_a_q  [$];
  logic [DW-1:0]    exp_b_q  [$];
  int vectors = 0;
  int miscompares = 0;
  logic [AW+DW-1:0] mon_w;
  logic [DW-1:0]    mon_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected RAM writes and read data whenever the DUT presents them
  always @(negedge clk_in) begin
    if (reset) begin
      if (mem_en && mem_we) begin
        if (exp_wr_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL ram_write: got addr %0d data 0x%0h expected no write", mem_addr, mem_wdata);
        end else begin
          mon_w = exp_wr_q.pop_front();
          check("ram_write", {12'd0, mem_addr, mem_wdata}, {12'd0, mon_w});
        end
      end
      if (rd_ack_a) begin
        if (exp_a_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL ack_a: got ack data 0x%0h expected no ack", rd_data_a);
        end else begin
          mon_d = exp_a_q.pop_front();
          check("rd_data_a", {16'd0, rd_data_a}, {16'd0, mon_d});
        end
      end
      if (rd_ack_b) begin
        if (exp_b_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL ack_b: got ack data 0x%0h expected no ack", rd_data_b);
        end else begin
          mon_d = exp_b_q.pop_front();
          check("rd_data_b", {16'd0, rd_data_b}, {16'd0, mon_d});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_wr_q.push_back({a, d});
    ref_mem[a] = d;
  endtask

  task automatic issue_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_pulse = 1'b1; wr_addr = a; wr_data = d;
    push_write(a, d);
    tick();
    wr_pulse = 1'b0;
    repeat (3) tick();
  endtask

  task automatic push_read(input bit port_b, input logic [AW-1:0] a);
    if (port_b) begin rd_req_b = 1'b1; rd_addr_b = a; exp_b_q.push_back(ref_mem[a]); end
    else        begin rd_req_a = 1'b1; rd_addr_a = a; exp_a_q.push_back(ref_mem[a]); end
  endtask

  // Runs cycles from relative cycle 'start', dropping each request on its ack
  task automatic watch(input int start, output int t_a, output int t_b, output int t_w);
    int k;
    k = start; t_a = -1; t_b = -1; t_w = -1;
    for (int n = 0; n < 30; n++) begin
      if (rd_ack_a && t_a < 0) t_a = k;
      if (rd_ack_b && t_b < 0) t_b = k;
      if (mem_we && t_w < 0)   t_w = k;
      if (rd_ack_a) rd_req_a = 1'b0;
      if (rd_ack_b) rd_req_b = 1'b0;
      if (!rd_req_a && !rd_req_b && !busy) break;
      tick();
      k++;
    end
    check("req_served", {30'd0, rd_req_a, rd_req_b}, 32'd0);
    rd_req_a = 1'b0;
    rd_req_b = 1'b0;
  endtask

  task automatic both_reads(input logic [AW-1:0] aa, input logic [AW-1:0] ab);
    int ta, tb, tw;
    bit first_b;
    first_b = !last_b_m;
    push_read(1'b0, aa);
    push_read(1'b1, ab);
    watch(0, ta, tb, tw);
    check("rr_ack_a_cycle", ta, first_b ? 32'd7 : 32'd3);
    check("rr_ack_b_cycle", tb, first_b ? 32'd3 : 32'd7);
    last_b_m = !first_b;
  endtask

  initial begin
    int ta, tb, tw;
    bit p;
    logic [AW-1:0] ra, rb;
    logic [DW-1:0] rd;
    reset = 1'b0; wr_pulse = 1'b0; wr_addr = 4'd0; wr_data = 16'd0;
    rd_req_a = 1'b0; rd_req_b = 1'b0; rd_addr_a = 4'd0; rd_addr_b = 4'd0; ovf_clr = 1'b0;
    last_b_m = 1'b1;
    #12;
    check("reset_outs", {14'd0, mem_en, mem_we, mem_addr, rd_ack_a, rd_ack_b, busy, wr_overflow, 8'd0}, 32'd0);
    check("reset_wdata", {16'd0, mem_wdata}, 32'd0);
    check("reset_rdata", {rd_data_a, rd_data_b}, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Fill RAM through the arbiter so reference and RAM agree
    for (int i = 0; i < 16; i++) issue_write(i[AW-1:0], 16'($urandom));

    // Write latency, plus a second write accepted in the draining WRITE cycle
    wr_pulse = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234; push_write(4'd3, 16'h1234);
    tick();
    wr_pulse = 1'b0;
    check("wr_cycle1_idle", {31'd0, mem_en}, 32'd0);
    tick();
    check("wr_cycle2", {12'd0, mem_en, mem_we, mem_addr, mem_wdata}, {12'd0, 1'b1, 1'b1, 4'd3, 16'h1234});
    wr_pulse = 1'b1; wr_addr = 4'd7; wr_data = 16'h5A5A; push_write(4'd7, 16'h5A5A);
    tick();
    wr_pulse = 1'b0;
    check("wr_cycle3_off", {31'd0, mem_en}, 32'd0);
    repeat (3) tick();
    check("drain_no_ovf", {31'd0, wr_overflow}, 32'd0);

    // Read latency on port A
    issue_write(4'd5, 16'hBEEF);
    push_read(1'b0, 4'd5); last_b_m = 1'b0;
    tick();
    check("rd_cycle1", {25'd0, mem_en, mem_we, 1'b0, mem_addr}, {25'd0, 1'b1, 1'b0, 1'b0, 4'd5});
    tick(); tick();
    check("rd_cycle3", {15'd0, rd_ack_a, rd_data_a}, {15'd0, 1'b1, 16'hBEEF});
    rd_req_a = 1'b0;
    tick();
    check("rd_ack_pulse", {31'd0, rd_ack_a}, 32'd0);
    tick();

    // Round robin after reset: A first, then alternate
    reset = 1'b0; tick(); reset = 1'b1; last_b_m = 1'b1; tick();
    both_reads(4'd1, 4'd2);
    both_reads(4'd1, 4'd2);

    // Write arriving during a B read is slotted between B and the pending A read
    push_read(1'b1, 4'd9); last_b_m = 1'b1;
    tick();
    wr_pulse = 1'b1; wr_addr = 4'd9; wr_data = 16'hC0DE; push_write(4'd9, 16'hC0DE);
    push_read(1'b0, 4'd9);
    tick();
    wr_pulse = 1'b0;
    watch(2, ta, tb, tw);
    check("order_ack_b", tb, 32'd3);
    check("order_write", tw, 32'd5);
    check("order_ack_a", ta, 32'd9);
    last_b_m = 1'b0;
    repeat (2) tick();

    // Overflow: buffer full during a read, then clear colliding with a drop
    push_read(1'b0, 4'd4); last_b_m = 1'b0;
    tick();
    wr_pulse = 1'b1; wr_addr = 4'd4; wr_data = 16'h1111; push_write(4'd4, 16'h1111);
    tick();
    wr_addr = 4'd4; wr_data = 16'h2222;
    tick();
    check("ovf_set", {30'd0, rd_ack_a, wr_overflow}, {30'd0, 1'b1, 1'b1});
    rd_req_a = 1'b0;
    wr_addr = 4'd6; wr_data = 16'h3333; ovf_clr = 1'b1;
    tick();
    wr_pulse = 1'b0; ovf_clr = 1'b0;
    check("ovf_set_wins", {31'd0, wr_overflow}, 32'd1);
    repeat (3) tick();
    check("ovf_sticky", {31'd0, wr_overflow}, 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", {31'd0, wr_overflow}, 32'd0);
    tick();

    // Reset during RDATA: outputs drop at once, no ack, fresh request served
    rd_req_b = 1'b1; rd_addr_b = 4'd2;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("async_reset", {26'd0, mem_en, mem_we, rd_ack_a, rd_ack_b, busy, wr_overflow}, 32'd0);
    rd_req_b = 1'b0;
    tick(); tick();
    reset = 1'b1; last_b_m = 1'b1;
    tick();
    push_read(1'b1, 4'd2);
    watch(0, ta, tb, tw);
    check("post_reset_ack_b", tb, 32'd3);
    tick();

    // Randomized mix of writes, single reads, contended reads and writes during reads
    for (int it = 0; it < 80; it++) begin
      ra = 4'($urandom); rb = 4'($urandom); rd = 16'($urandom); p = 1'($urandom);
      case ($urandom_range(0, 3))
        0: issue_write(ra, rd);
        1: begin
          push_read(p, ra); last_b_m = p;
          watch(0, ta, tb, tw);
          check("rand_single_lat", p ? tb : ta, 32'd3);
          tick();
        end
        2: begin
          both_reads(ra, rb);
          tick();
        end
        default: begin
          push_read(p, ra); last_b_m = p;
          tick();
          wr_pulse = 1'b1; wr_addr = rb; wr_data = rd; push_write(rb, rd);
          tick();
          wr_pulse = 1'b0;
          watch(2, ta, tb, tw);
          check("rand_wdr_lat", p ? tb : ta, 32'd3);
          repeat (3) tick();
        end
      endcase
    end
    repeat (4) tick();
    check("queues_drained", exp_wr_q.size() + exp_a_q.size() + exp_b_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
